// File: rtl/udma_i2s_tdm_master.sv
// udma_i2s_tdm_master: I2S/TDM serial master with a TX holding register and an RX word stream
module udma_i2s_tdm_master #(
    parameter int NUM_SLOTS = 2,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_clk_div_i,
    input  logic [4:0]           cfg_bits_word_i,
    input  logic [3:0]           cfg_num_slots_i,
    input  logic                 cfg_lsb_first_i,
    input  logic [31:0]          tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [31:0]          rx_data_o,
    output logic [3:0]           rx_slot_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 pad_sck_o,
    output logic                 pad_ws_o,
    output logic                 pad_sd_o,
    input  logic                 pad_sd_i,
    output logic                 busy_o,
    output logic                 underrun_o,
    output logic                 overrun_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRE   = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    localparam logic [3:0] MAX_SLOT = 4'(NUM_SLOTS - 1);

    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, cnt_q;
    logic [4:0]           bits_q, bit_q, idx;
    logic [3:0]           slots_q, slot_q, rx_slot_q;
    logic                 lsb_q, sck_q, hold_v_q, rx_valid_q, underrun_q, overrun_q;
    logic [31:0]          tx_q, hold_q, rx_sh_q, rx_data_q, rx_word;
    logic                 active, tc, fall, rise, last_bit, last_slot, stop, load, deliver, xfer;

    assign active     = (state_q == RUN) || (state_q == DRAIN);
    assign tc         = (state_q != IDLE) && (cnt_q == div_q);
    assign fall       = tc && sck_q;
    assign rise       = tc && !sck_q;
    assign last_bit   = bit_q == bits_q;
    assign last_slot  = slot_q == slots_q;
    assign stop       = fall && (state_q == DRAIN) && last_bit && last_slot;
    assign load       = fall && ((state_q == PRE) || (active && last_bit)) && !stop;
    assign deliver    = rise && active && last_bit;
    assign idx        = lsb_q ? bit_q : bits_q - bit_q;
    assign rx_word    = rx_sh_q | (32'(pad_sd_i) << idx);
    assign tx_ready_o = !hold_v_q && (state_q != IDLE);
    assign xfer       = tx_valid_i && tx_ready_o;
    assign busy_o     = state_q != IDLE;
    assign pad_sck_o  = sck_q;
    assign pad_ws_o   = (state_q == PRE) || (active && last_bit && last_slot);
    assign pad_sd_o   = active && tx_q[idx];
    assign rx_data_o  = rx_data_q;
    assign rx_slot_o  = rx_slot_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;
    assign overrun_o  = overrun_q;

    // Next state: run enable only counts in IDLE/PRE/RUN; DRAIN always completes its frame
    always_comb begin
        state_d = state_q == IDLE  ? (cfg_en_i ? PRE : IDLE) :
                  state_q == DRAIN ? (stop ? IDLE : DRAIN) :
                  !cfg_en_i        ? DRAIN :
                  (state_q == PRE && fall) ? RUN : state_q;
    end

    // Divider, bit/slot counters, TX/RX shift paths and stream handshakes
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            bits_q     <= '0;
            bit_q      <= '0;
            slots_q    <= '0;
            slot_q     <= '0;
            lsb_q      <= 1'b0;
            sck_q      <= 1'b0;
            tx_q       <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_slot_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_v_q   <= (state_q == IDLE) ? 1'b0 : xfer ? 1'b1 : load ? 1'b0 : hold_v_q;
            underrun_q <= load && !hold_v_q;
            rx_valid_q <= deliver || (rx_valid_q && !rx_ready_i);
            overrun_q  <= deliver && rx_valid_q && !rx_ready_i;
            if (xfer) hold_q <= tx_data_i;
            if (deliver) begin
                rx_data_q <= rx_word;
                rx_slot_q <= slot_q;
            end
            if (state_q == IDLE) begin
                cnt_q   <= '0;
                sck_q   <= 1'b0;
                bit_q   <= '0;
                slot_q  <= '0;
                tx_q    <= '0;
                rx_sh_q <= '0;
                if (cfg_en_i) begin
                    div_q   <= cfg_clk_div_i;
                    bits_q  <= cfg_bits_word_i;
                    slots_q <= (cfg_num_slots_i > MAX_SLOT) ? MAX_SLOT : cfg_num_slots_i;
                    lsb_q   <= cfg_lsb_first_i;
                end
            end else begin
                cnt_q <= tc ? '0 : cnt_q + DIV_WIDTH'(1);
                sck_q <= sck_q ^ tc;
                if (load) begin
                    bit_q  <= '0;
                    slot_q <= (state_q == PRE || last_slot) ? 4'd0 : slot_q + 4'd1;
                    tx_q   <= hold_v_q ? hold_q : '0;
                end else if (fall && !stop) begin
                    bit_q <= bit_q + 5'd1;
                end
                if (rise && active) rx_sh_q <= last_bit ? '0 : rx_word;
            end
        end
    end
endmodule
